// File: rtl/alu_ctrl_pkg.sv
// Shared encodings for the ALU control stage: select codes, function codes,
// main-decoder op classes, FSM states and the decoder result record.
package alu_ctrl_pkg;

  typedef enum logic [2:0] {
    SEL_ADD = 3'b000,
    SEL_SUB = 3'b001,
    SEL_INC = 3'b010,
    SEL_AND = 3'b011,
    SEL_OR  = 3'b100,
    SEL_MUL = 3'b101
  } alu_sel_e;

  localparam logic [5:0] FUNC_ADD = 6'h20;
  localparam logic [5:0] FUNC_SUB = 6'h21;
  localparam logic [5:0] FUNC_INC = 6'h22;
  localparam logic [5:0] FUNC_AND = 6'h23;
  localparam logic [5:0] FUNC_OR  = 6'h24;
  localparam logic [5:0] FUNC_MUL = 6'h25;

  typedef enum logic [1:0] {
    ALUOP_ADD  = 2'b00,
    ALUOP_FUNC = 2'b01,
    ALUOP_SUB  = 2'b10,
    ALUOP_ILL  = 2'b11
  } aluop_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HOLD,
    ST_MULTI
  } state_e;

  typedef struct packed {
    alu_sel_e sel;
    logic     is_mul;
    logic     illegal;
  } dec_t;

endpackage

// File: rtl/alu_ctrl_if.sv
// ID-to-EX handshake bundle of the ALU control stage. The master drives the
// instruction, flush and EX readiness; the slave (the stage) drives the rest.
interface alu_ctrl_if #(
  parameter int FUNC_W = 6,
  parameter int SEL_W  = 3
);
  logic              valid_in;
  logic [FUNC_W-1:0] func_in;
  logic [1:0]        aluop_in;
  logic              ready_out;
  logic              flush_in;
  logic              ex_ready_in;
  logic              valid_out;
  logic [SEL_W-1:0]  alu_sel_out;
  logic              mul_last_out;
  logic              illegal_out;

  modport master (
    output valid_in, func_in, aluop_in, flush_in, ex_ready_in,
    input  ready_out, valid_out, alu_sel_out, mul_last_out, illegal_out
  );

  modport slave (
    input  valid_in, func_in, aluop_in, flush_in, ex_ready_in,
    output ready_out, valid_out, alu_sel_out, mul_last_out, illegal_out
  );
endinterface

// File: rtl/alu_ctrl_decode.sv
// Combinational ALU-control decode: (aluop, func) -> select, MUL flag, illegal.
// Illegal encodings fall back to ADD so the pipeline keeps flowing.
module alu_ctrl_decode
  import alu_ctrl_pkg::*;
#(
  parameter int FUNC_W = 6
) (
  input  logic [1:0]        aluop,
  input  logic [FUNC_W-1:0] func,
  output dec_t              dec
);

  always_comb begin
    // NOTE: defaults assigned first so every path drives every field; no latch.
    dec.sel     = SEL_ADD;
    dec.is_mul  = 1'b0;
    dec.illegal = 1'b0;
    unique case (aluop_e'(aluop))
      ALUOP_ADD: dec.sel = SEL_ADD;
      ALUOP_SUB: dec.sel = SEL_SUB;
      ALUOP_ILL: dec.illegal = 1'b1;
      ALUOP_FUNC: begin
        case (func)
          FUNC_W'(FUNC_ADD): dec.sel = SEL_ADD;
          FUNC_W'(FUNC_SUB): dec.sel = SEL_SUB;
          FUNC_W'(FUNC_INC): dec.sel = SEL_INC;
          FUNC_W'(FUNC_AND): dec.sel = SEL_AND;
          FUNC_W'(FUNC_OR):  dec.sel = SEL_OR;
          FUNC_W'(FUNC_MUL): begin
            dec.sel    = SEL_MUL;
            dec.is_mul = 1'b1;
          end
          default: dec.illegal = 1'b1;
        endcase
      end
      default: dec.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_ctrl_seq.sv
// ALU control stage: decodes ID ops, presents a registered select to EX behind
// valid/ready, and holds MUL for MUL_CYCLES. Optional perf counters: ALU_CTRL_PERF_EN.
module alu_ctrl_seq
  import alu_ctrl_pkg::*;
#(
  parameter int FUNC_W     = 6,
  parameter int SEL_W      = 3,
  parameter int MUL_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  alu_ctrl_if.slave   bus
`ifdef ALU_CTRL_PERF_EN
  ,
  output logic [31:0] perf_ops_out,
  output logic [31:0] perf_stall_out
`endif
);

  localparam int CNT_W = $clog2(MUL_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MUL_CYCLES - 1);

  if (MUL_CYCLES < 2 || MUL_CYCLES > 16) begin : g_bad_mul_cycles
    $error("alu_ctrl_seq: MUL_CYCLES must lie in 2..16");
  end
  if (SEL_W < 3) begin : g_bad_sel_w
    $error("alu_ctrl_seq: SEL_W must be at least 3");
  end
  if (FUNC_W < 6) begin : g_bad_func_w
    $error("alu_ctrl_seq: FUNC_W must be at least 6");
  end

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  alu_sel_e         sel_q;
  logic             illegal_q;
  dec_t             dec;
  logic             ready, valid, mul_last, accept;

  alu_ctrl_decode #(.FUNC_W(FUNC_W)) u_decode (
    .aluop (bus.aluop_in),
    .func  (bus.func_in),
    .dec   (dec)
  );

  assign accept = bus.valid_in && ready;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: non-blocking so every flop samples values from before the edge.
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; flush overrides everything, including a same-cycle accept.
  always_comb begin
    state_d = state_q;
    if (bus.flush_in) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: if (accept) state_d = dec.is_mul ? ST_MULTI : ST_HOLD;
        ST_HOLD: begin
          if (accept)               state_d = dec.is_mul ? ST_MULTI : ST_HOLD;
          else if (bus.ex_ready_in) state_d = ST_IDLE;
        end
        ST_MULTI: if (cnt_q == '0 && bus.ex_ready_in) state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Outputs; ready never looks at valid_in, so ID sees no combinational loop.
  always_comb begin
    ready    = 1'b0;
    valid    = 1'b0;
    mul_last = 1'b0;
    unique case (state_q)
      ST_IDLE: ready = 1'b1;
      ST_HOLD: begin
        valid = 1'b1;
        ready = bus.ex_ready_in;
      end
      ST_MULTI: begin
        valid    = 1'b1;
        mul_last = (cnt_q == '0);
      end
      default: ready = 1'b0;
    endcase
  end

  // Select, illegal flag and MUL countdown. The countdown ignores ex_ready_in
  // because the MUL unit is internally pipelined; it parks at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      sel_q     <= SEL_ADD;
      illegal_q <= 1'b0;
    end else if (bus.flush_in) begin
      cnt_q     <= '0;
      illegal_q <= 1'b0;
    end else if (accept) begin
      sel_q     <= dec.sel;
      illegal_q <= dec.illegal;
      cnt_q     <= dec.is_mul ? CNT_LOAD : '0;
    end else if (state_q == ST_MULTI && cnt_q != '0) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  assign bus.ready_out    = ready;
  assign bus.valid_out    = valid;
  assign bus.alu_sel_out  = SEL_W'(sel_q);
  assign bus.mul_last_out = mul_last;
  assign bus.illegal_out  = illegal_q && valid;

`ifdef ALU_CTRL_PERF_EN
  logic [31:0] ops_q, stall_q;

  // Saturating counters; flush discards the op but not the history.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ops_q   <= '0;
      stall_q <= '0;
    end else begin
      if (accept && !bus.flush_in && ops_q != '1)  ops_q   <= ops_q + 32'd1;
      if (bus.valid_in && !ready && stall_q != '1) stall_q <= stall_q + 32'd1;
    end
  end

  assign perf_ops_out   = ops_q;
  assign perf_stall_out = stall_q;
`endif

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Self-checking bench for alu_ctrl_seq: transaction-level reference model checked
// every negedge, plus directed vectors with hand-computed expectations.
module tb_alu_ctrl_seq;

  localparam int MC = 4;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  alu_ctrl_if #(.FUNC_W(6), .SEL_W(3)) bus ();

`ifdef ALU_CTRL_PERF_EN
  logic [31:0] perf_ops, perf_stall;
`endif

  alu_ctrl_seq #(.FUNC_W(6), .SEL_W(3), .MUL_CYCLES(MC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
`ifdef ALU_CTRL_PERF_EN
    ,
    .perf_ops_out   (perf_ops),
    .perf_stall_out (perf_stall)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference decode table: {illegal, is_mul, sel[2:0]}.
  function automatic logic [4:0] ref_dec(input logic [1:0] op, input logic [5:0] fn);
    case (op)
      2'b00: return 5'b00_000;
      2'b10: return 5'b00_001;
      2'b11: return 5'b10_000;
      default: begin
        case (fn)
          6'h20: return 5'b00_000;
          6'h21: return 5'b00_001;
          6'h22: return 5'b00_010;
          6'h23: return 5'b00_011;
          6'h24: return 5'b00_100;
          6'h25: return 5'b01_101;
          default: return 5'b10_000;
        endcase
      end
    endcase
  endfunction

  // Model: the op currently presented to EX and how many cycles it has been there.
  logic       m_valid, m_mul, m_ill;
  logic [2:0] m_sel;
  int         m_age;
  logic       m_ready, m_take, m_done, m_last;
  logic [4:0] m_dec;

  assign m_ready = !(m_valid && m_mul) && (!m_valid || bus.ex_ready_in);
  assign m_take  = bus.valid_in && m_ready;
  assign m_last  = m_valid && m_mul && (m_age >= MC - 1);
  assign m_done  = bus.ex_ready_in && (!m_mul || m_age >= MC - 1);
  assign m_dec   = ref_dec(bus.aluop_in, bus.func_in);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0;
      m_mul   <= 1'b0;
      m_ill   <= 1'b0;
      m_sel   <= 3'b000;
      m_age   <= 0;
    end else if (bus.flush_in) begin
      m_valid <= 1'b0;
      m_age   <= 0;
    end else if (m_take) begin
      m_valid <= 1'b1;
      m_ill   <= m_dec[4];
      m_mul   <= m_dec[3];
      m_sel   <= m_dec[2:0];
      m_age   <= 0;
    end else if (m_valid && m_done) begin
      m_valid <= 1'b0;
    end else if (m_valid) begin
      m_age <= m_age + 1;
    end
  end

`ifdef ALU_CTRL_PERF_EN
  logic [31:0] m_ops, m_stall;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ops   <= '0;
      m_stall <= '0;
    end else begin
      if (m_take && !bus.flush_in && m_ops != '1)       m_ops   <= m_ops + 1;
      if (bus.valid_in && !m_ready && m_stall != '1)    m_stall <= m_stall + 1;
    end
  end
`endif

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    check("ready_out", 32'(bus.ready_out), 32'(m_ready));
    check("valid_out", 32'(bus.valid_out), 32'(m_valid));
    if (m_valid) check("alu_sel_out", 32'(bus.alu_sel_out), 32'(m_sel));
    check("mul_last_out", 32'(bus.mul_last_out), 32'(m_last));
    check("illegal_out", 32'(bus.illegal_out), 32'(m_valid && m_ill));
`ifdef ALU_CTRL_PERF_EN
    check("perf_ops_out", perf_ops, m_ops);
    check("perf_stall_out", perf_stall, m_stall);
`endif
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] op, input logic [5:0] fn);
    bus.valid_in = v;
    bus.aluop_in = op;
    bus.func_in  = fn;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n           = 1'b1;
    bus.flush_in    = 1'b0;
    bus.ex_ready_in = 1'b1;
    drive(1'b0, 2'b00, 6'h00);
    #1 rst_n = 1'b0;
    #1;
    check("rst valid", 32'(bus.valid_out), 32'd0);
    check("rst sel", 32'(bus.alu_sel_out), 32'd0);
    check("rst mul_last", 32'(bus.mul_last_out), 32'd0);
    check("rst illegal", 32'(bus.illegal_out), 32'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();

    // Single SUB via function field.
    drive(1'b1, 2'b01, 6'h21); tick(); drive(1'b0, 2'b00, 6'h00); #1;
    check("t1 valid", 32'(bus.valid_out), 32'd1);
    check("t1 sel", 32'(bus.alu_sel_out), 32'd1);
    check("t1 illegal", 32'(bus.illegal_out), 32'd0);
    tick(); #1;
    check("t1 drop", 32'(bus.valid_out), 32'd0);

    // Back-to-back ADD, SUB.
    drive(1'b1, 2'b00, 6'h00); tick(); drive(1'b1, 2'b10, 6'h00); #1;
    check("b2b sel0", 32'(bus.alu_sel_out), 32'd0);
    check("b2b valid0", 32'(bus.valid_out), 32'd1);
    check("b2b ready0", 32'(bus.ready_out), 32'd1);
    tick(); drive(1'b0, 2'b00, 6'h00); #1;
    check("b2b sel1", 32'(bus.alu_sel_out), 32'd1);
    check("b2b valid1", 32'(bus.valid_out), 32'd1);
    check("b2b ready1", 32'(bus.ready_out), 32'd1);
    tick(); #1;
    check("b2b drop", 32'(bus.valid_out), 32'd0);

    // MUL occupancy with a held follow-on ADD.
    drive(1'b1, 2'b01, 6'h25); tick(); drive(1'b1, 2'b01, 6'h20);
    for (int i = 1; i <= MC; i++) begin
      #1;
      check("mul valid", 32'(bus.valid_out), 32'd1);
      check("mul sel", 32'(bus.alu_sel_out), 32'd5);
      check("mul ready", 32'(bus.ready_out), 32'd0);
      check("mul last", 32'(bus.mul_last_out), (i == MC) ? 32'd1 : 32'd0);
      tick();
    end
    #1;
    check("mul after ready", 32'(bus.ready_out), 32'd1);
    check("mul after valid", 32'(bus.valid_out), 32'd0);
    tick(); drive(1'b0, 2'b00, 6'h00); #1;
    check("mul follow sel", 32'(bus.alu_sel_out), 32'd0);
    check("mul follow valid", 32'(bus.valid_out), 32'd1);
    tick();

    // Backpressure in HOLD.
    drive(1'b1, 2'b01, 6'h23); tick();
    drive(1'b1, 2'b01, 6'h24); bus.ex_ready_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("bp sel", 32'(bus.alu_sel_out), 32'd3);
      check("bp valid", 32'(bus.valid_out), 32'd1);
      check("bp ready", 32'(bus.ready_out), 32'd0);
      tick();
    end
    bus.ex_ready_in = 1'b1; #1;
    check("bp release ready", 32'(bus.ready_out), 32'd1);
    tick(); drive(1'b0, 2'b00, 6'h00); #1;
    check("bp next sel", 32'(bus.alu_sel_out), 32'd4);
    tick();

    // MUL final cycle stalled by EX.
    drive(1'b1, 2'b01, 6'h25); tick(); drive(1'b0, 2'b00, 6'h00);
    bus.ex_ready_in = 1'b0;
    repeat (3) tick();
    #1; check("mulbp last4", 32'(bus.mul_last_out), 32'd1);
    tick(); #1;
    check("mulbp last5", 32'(bus.mul_last_out), 32'd1);
    check("mulbp sel5", 32'(bus.alu_sel_out), 32'd5);
    tick(); #1;
    check("mulbp last6", 32'(bus.mul_last_out), 32'd1);
    bus.ex_ready_in = 1'b1; #1;
    check("mulbp ready rel", 32'(bus.ready_out), 32'd0);
    tick(); #1;
    check("mulbp done valid", 32'(bus.valid_out), 32'd0);
    check("mulbp done last", 32'(bus.mul_last_out), 32'd0);

    // Illegal encodings, then normal flow.
    drive(1'b1, 2'b01, 6'h3f); tick(); drive(1'b0, 2'b00, 6'h00); #1;
    check("ill func sel", 32'(bus.alu_sel_out), 32'd0);
    check("ill func flag", 32'(bus.illegal_out), 32'd1);
    tick(); #1;
    check("ill func clear", 32'(bus.illegal_out), 32'd0);
    drive(1'b1, 2'b11, 6'h21); tick(); drive(1'b0, 2'b00, 6'h00); #1;
    check("ill op sel", 32'(bus.alu_sel_out), 32'd0);
    check("ill op flag", 32'(bus.illegal_out), 32'd1);
    tick();
    drive(1'b1, 2'b01, 6'h22); tick(); drive(1'b0, 2'b00, 6'h00); #1;
    check("inc sel", 32'(bus.alu_sel_out), 32'd2);
    check("inc flag", 32'(bus.illegal_out), 32'd0);
    tick();

    // Flush in MULTI cycle 2 with a simultaneous valid_in.
    drive(1'b1, 2'b01, 6'h25); tick(); drive(1'b0, 2'b00, 6'h00); tick();
    drive(1'b1, 2'b00, 6'h00); bus.flush_in = 1'b1; tick();
    bus.flush_in = 1'b0; drive(1'b0, 2'b00, 6'h00); #1;
    check("flush valid", 32'(bus.valid_out), 32'd0);
    check("flush last", 32'(bus.mul_last_out), 32'd0);
    check("flush ready", 32'(bus.ready_out), 32'd1);
    tick(); #1;
    check("flush no accept", 32'(bus.valid_out), 32'd0);

    // Flush discards an accept from IDLE.
    drive(1'b1, 2'b10, 6'h00); bus.flush_in = 1'b1; tick();
    bus.flush_in = 1'b0; drive(1'b0, 2'b00, 6'h00); #1;
    check("flush idle valid", 32'(bus.valid_out), 32'd0);
    tick();

    // Asynchronous reset mid-MUL.
    drive(1'b1, 2'b01, 6'h25); tick(); drive(1'b0, 2'b00, 6'h00); tick();
    #2 rst_n = 1'b0; #1;
    check("areset valid", 32'(bus.valid_out), 32'd0);
    check("areset sel", 32'(bus.alu_sel_out), 32'd0);
    check("areset last", 32'(bus.mul_last_out), 32'd0);
    check("areset illegal", 32'(bus.illegal_out), 32'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    drive(1'b1, 2'b00, 6'h00); bus.flush_in = 1'b1; tick();
    bus.flush_in = 1'b0; tick();
    drive(1'b0, 2'b00, 6'h00); #1;
    check("post reset valid", 32'(bus.valid_out), 32'd1);
`ifdef ALU_CTRL_PERF_EN
    check("perf ops excl flush", perf_ops, 32'd1);
`endif
    repeat (2) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
